// File: rtl/mchan_regf_pkg.sv
// Shared constants for the multi-channel register file: address map, field positions
// and the legal parameter ranges.
package mchan_regf_pkg;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 15;
  localparam int DW_MIN     = 1;
  localparam int DW_MAX     = 32;

  localparam int ADDR_W    = 13;
  localparam int CH_SHIFT  = 4;
  localparam int CH_STRIDE = 1 << CH_SHIFT;

  localparam logic [CH_SHIFT-1:0] OFF_IRQ  = 4'h0;
  localparam logic [CH_SHIFT-1:0] OFF_CTRL = 4'h0;
  localparam logic [CH_SHIFT-1:0] OFF_RX   = 4'h4;
  localparam logic [CH_SHIFT-1:0] OFF_TX   = 4'h8;
  localparam logic [CH_SHIFT-1:0] OFF_STAT = 4'hC;

  localparam int CTRL_ENA_BIT   = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_OVF_BIT   = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_IRQ,
    SEL_CTRL,
    SEL_RX,
    SEL_TX,
    SEL_STAT
  } reg_sel_e;

endpackage

// File: rtl/mchan_regf_ch.sv
// One channel's storage: CTRL, RX capture with full/overflow tracking, TX, and its
// interrupt pending term.
module mchan_regf_ch
  import mchan_regf_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          main_clk_i,
  input  logic          main_rst_an_i,
  input  logic          ctrl_we,
  input  logic          tx_we,
  input  logic          stat_we,
  input  logic          rx_rd,
  input  logic [31:0]   wdata,
  input  logic          rx_wr,
  input  logic [DW-1:0] rx_data,
  output logic          ena,
  output logic          irq_en,
  output logic [DW-1:0] rx_val,
  output logic [DW-1:0] tx_val,
  output logic          full,
  output logic          ovf,
  output logic          pending
);

  logic rx_cap;
  logic unused_wdata;

  assign rx_cap       = rx_wr & ena;
  assign pending      = (full | ovf) & irq_en;
  assign unused_wdata = ^wdata;

  // A capture always beats a same-cycle RX read, and a new overflow beats W1C.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      ena    <= 1'b0;
      irq_en <= 1'b0;
      rx_val <= '0;
      tx_val <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (ctrl_we) begin
        ena    <= wdata[CTRL_ENA_BIT];
        irq_en <= wdata[CTRL_IRQEN_BIT];
      end
      if (tx_we) tx_val <= wdata[DW-1:0];
      if (rx_cap) begin
        rx_val <= rx_data;
        full   <= 1'b1;
      end else if (rx_rd) begin
        full <= 1'b0;
      end
      if (rx_cap && full) ovf <= 1'b1;
      else if (stat_we && wdata[STAT_OVF_BIT]) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/mchan_regf.sv
// Bus-accessible register file for NUM_CH identical rx/tx channels: address decode,
// registered read response/error, and the combined interrupt.
module mchan_regf
  import mchan_regf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_an_i,
  input  logic                 mem_ena_i,
  input  logic [12:0]          mem_addr_i,
  input  logic                 mem_wena_i,
  input  logic [31:0]          mem_wdata_i,
  output logic [31:0]          mem_rdata_o,
  output logic                 mem_rvld_o,
  output logic                 mem_err_o,
  output logic [NUM_CH-1:0]    regf_ena_o,
  output logic [NUM_CH*DW-1:0] regf_tx_data_o,
  input  logic [NUM_CH*DW-1:0] regf_rx_data_i,
  input  logic [NUM_CH-1:0]    regf_rx_wr_i,
  output logic                 irq_o
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("mchan_regf: NUM_CH out of range");
  end
  if (DW < DW_MIN || DW > DW_MAX) begin : g_bad_dw
    $error("mchan_regf: DW out of range");
  end

  logic [ADDR_W-1:0]   slot;
  logic [CH_SHIFT-1:0] off;
  reg_sel_e            sel;
  logic                acc_err;
  logic                acc_ok;
  logic                rd_acc;
  logic [NUM_CH-1:0]   ch_hit;
  logic [NUM_CH-1:0]   ch_irq_en;
  logic [NUM_CH-1:0]   ch_full;
  logic [NUM_CH-1:0]   ch_ovf;
  logic [NUM_CH-1:0]   ch_pend;
  logic [DW-1:0]       ch_rx [NUM_CH];
  logic [DW-1:0]       ch_tx [NUM_CH];
  logic [31:0]         rdata_p0;
  logic [31:0]         rdata_p1;
  logic                vld_p1;
  logic                err_p1;
  logic                irq_p1;

  assign slot = mem_addr_i >> CH_SHIFT;
  assign off  = mem_addr_i[CH_SHIFT-1:0];

  // Slot 0 holds only the IRQ word; slots 1..NUM_CH are channels 0..NUM_CH-1.
  always_comb begin
    sel = SEL_NONE;
    if (slot == '0) begin
      if (off == OFF_IRQ) sel = SEL_IRQ;
    end else if (slot <= ADDR_W'(NUM_CH)) begin
      case (off)
        OFF_CTRL: sel = SEL_CTRL;
        OFF_RX:   sel = SEL_RX;
        OFF_TX:   sel = SEL_TX;
        OFF_STAT: sel = SEL_STAT;
        default:  sel = SEL_NONE;
      endcase
    end
  end

  assign acc_err = mem_ena_i &
                   ((sel == SEL_NONE) | (mem_wena_i & ((sel == SEL_IRQ) | (sel == SEL_RX))));
  assign acc_ok  = mem_ena_i & ~acc_err;
  assign rd_acc  = mem_ena_i & ~mem_wena_i;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_hit[c] = (slot == ADDR_W'(c + 1));

    mchan_regf_ch #(
      .DW (DW)
    ) u_ch (
      .main_clk_i    (main_clk_i),
      .main_rst_an_i (main_rst_an_i),
      .ctrl_we       (acc_ok & mem_wena_i & ch_hit[c] & (sel == SEL_CTRL)),
      .tx_we         (acc_ok & mem_wena_i & ch_hit[c] & (sel == SEL_TX)),
      .stat_we       (acc_ok & mem_wena_i & ch_hit[c] & (sel == SEL_STAT)),
      .rx_rd         (acc_ok & ~mem_wena_i & ch_hit[c] & (sel == SEL_RX)),
      .wdata         (mem_wdata_i),
      .rx_wr         (regf_rx_wr_i[c]),
      .rx_data       (regf_rx_data_i[c*DW +: DW]),
      .ena           (regf_ena_o[c]),
      .irq_en        (ch_irq_en[c]),
      .rx_val        (ch_rx[c]),
      .tx_val        (ch_tx[c]),
      .full          (ch_full[c]),
      .ovf           (ch_ovf[c]),
      .pending       (ch_pend[c])
    );

    assign regf_tx_data_o[c*DW +: DW] = ch_tx[c];
  end

  always_comb begin
    rdata_p0 = '0;
    if (sel == SEL_IRQ) rdata_p0[NUM_CH-1:0] = ch_pend;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) begin
        case (sel)
          SEL_CTRL: begin
            rdata_p0[CTRL_ENA_BIT]   = regf_ena_o[c];
            rdata_p0[CTRL_IRQEN_BIT] = ch_irq_en[c];
          end
          SEL_RX:   rdata_p0[DW-1:0] = ch_rx[c];
          SEL_TX:   rdata_p0[DW-1:0] = ch_tx[c];
          SEL_STAT: begin
            rdata_p0[STAT_FULL_BIT] = ch_full[c];
            rdata_p0[STAT_OVF_BIT]  = ch_ovf[c];
          end
          default: ;
        endcase
      end
    end
  end

  // p0 -> p1: registered bus response and interrupt.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      irq_p1   <= 1'b0;
    end else begin
      rdata_p1 <= (rd_acc & ~acc_err) ? rdata_p0 : '0;
      vld_p1   <= rd_acc;
      err_p1   <= acc_err;
      irq_p1   <= |ch_pend;
    end
  end

  assign mem_rdata_o = rdata_p1;
  assign mem_rvld_o  = vld_p1;
  assign mem_err_o   = err_p1;
  assign irq_o       = irq_p1;

endmodule

// File: doc/mchan_regf.md
MCHAN_REGF -- requirements
Module: mchan_regf

Interface
REQ-001 Parameter SHALL be NUM_CH, default 4, number of identical channels, range 1..15.
REQ-002 Parameter SHALL be DW, default 16, channel data width, range 1..32.
REQ-003 Port SHALL be main_clk_i  in  1  clock; all flops rising-edge.
REQ-004 Port SHALL be main_rst_an_i  in  1  reset, asynchronous, active-low.
REQ-005 Port SHALL be mem_ena_i  in  1  bus access strobe.
REQ-006 Port SHALL be mem_addr_i  in  13  byte address.
REQ-007 Port SHALL be mem_wena_i  in  1  1=write, 0=read.
REQ-008 Port SHALL be mem_wdata_i  in  32  write data.
REQ-009 Port SHALL be mem_rdata_o  out  32  read data, registered.
REQ-010 Port SHALL be mem_rvld_o  out  1  read data/err valid, registered.
REQ-011 Port SHALL be mem_err_o  out  1  access error, registered.
REQ-012 Port SHALL be regf_ena_o  out  NUM_CH  per-channel enable.
REQ-013 Port SHALL be regf_tx_data_o  out  NUM_CH*DW  per-channel tx value, channel c at [c*DW +: DW].
REQ-014 Port SHALL be regf_rx_data_i  in  NUM_CH*DW  per-channel rx value, same packing.
REQ-015 Port SHALL be regf_rx_wr_i  in  NUM_CH  core rx capture strobe, one cycle per word.
REQ-016 Port SHALL be irq_o  out  1  level interrupt, registered.

Function
REQ-017 Address map SHALL be: 0x000 IRQ (RO, bits[NUM_CH-1:0] pending); channel c base 0x10*(c+1): +0x0 CTRL (RW: bit0 ena, bit1 irq_en), +0x4 RX (RO, DW bits), +0x8 TX (RW, DW bits), +0xC STAT (bit0 full RO, bit1 ovf W1C).
REQ-018 Access to an unmapped address, or write to IRQ/RX, SHALL raise mem_err_o for one cycle after the access with no state change; a read then returns 0.
REQ-019 Writes SHALL update storage at the clock edge ending the access cycle; unused wdata bits ignored.
REQ-020 Reads SHALL return mem_rdata_o and mem_rvld_o=1 exactly one cycle after the access cycle, unused upper bits zero; mem_rdata_o=0 when mem_rvld_o=0.
REQ-021 Write accesses SHALL not assert mem_rvld_o.
REQ-022 regf_rx_wr_i[c]=1 SHALL capture regf_rx_data_i slice into RX[c] and set full[c]; if full[c] already set, ovf[c] SHALL also set (data overwritten).
REQ-023 Bus read of RX[c] SHALL clear full[c] at end of access cycle, unless regf_rx_wr_i[c] is asserted same cycle: then new data captured, full stays 1, read returns old data.
REQ-024 Writing 1 to STAT bit1 SHALL clear ovf[c]; a simultaneous new overflow SHALL win (ovf stays 1).
REQ-025 pending[c] SHALL equal (full[c] or ovf[c]) and irq_en[c]; irq_o SHALL be OR of pending, registered, one cycle latency.
REQ-026 regf_rx_wr_i[c] SHALL be ignored while ena[c]=0.
REQ-027 regf_ena_o and regf_tx_data_o SHALL be driven directly from storage flops.

Reset
REQ-028 On main_rst_an_i low all flops SHALL clear asynchronously: CTRL, RX, TX, full, ovf, irq_o, mem_rdata_o, mem_rvld_o, mem_err_o = 0.
REQ-029 Reset mid-access SHALL discard the pending read response; no mem_rvld_o after release.

Structure
REQ-030 Package mchan_regf_pkg SHALL hold address offsets, channel stride 0x10, field bit positions and the NUM_CH/DW range limits.
REQ-031 Per-channel storage (CTRL, RX, TX, full, ovf, pending) SHALL be sub-module mchan_regf_ch, instantiated NUM_CH times via generate; decode, read-mux and irq register stay in top.

Verification
REQ-032 Reset then read 0x010..0x01C -> each returns 0 with mem_rvld_o=1 one cycle later, mem_err_o=0, irq_o=0.
REQ-033 Write 0x018=0xABCD (DW=16), read 0x018 -> 0x0000ABCD; regf_tx_data_o[15:0]=0xABCD next cycle.
REQ-034 ena[0]=1, irq_en[0]=1, rx_wr with 0x1234 -> STAT=0x1, irq_o=1 one cycle after full; read 0x014 -> 0x1234, then STAT=0x0, irq_o falls.
REQ-035 Two rx_wr (0x1111, 0x2222) without read -> RX=0x2222, STAT=0x3; write 0x01C=0x2 -> STAT=0x1; W1C same cycle as third rx_wr -> STAT stays 0x3.
REQ-036 Read 0x014 in the same cycle as rx_wr 0x5555 with full=1 -> returns previous data, STAT bit0 stays 1, RX=0x5555.
REQ-037 Write 0x004 and read 0x0FF0 -> mem_err_o=1 one cycle later each, no state change; reset asserted during a read -> no mem_rvld_o after release.
